// File: rtl/iob_reg_arb_pkg.sv
// Shared configuration for the iob_reg_arb register arbiter slice.
// Holds the default parameter values and the FSM state encoding.
// No logic; imported by the arbiter top.
package iob_reg_arb_pkg;

    localparam int          IOB_REG_ARB_N_REQ   = 4;
    localparam int          IOB_REG_ARB_DATA_W  = 32;
    localparam logic [31:0] IOB_REG_ARB_RST_VAL = 32'h0;

    typedef enum logic {
        IOB_REG_ARB_IDLE   = 1'b0,
        IOB_REG_ARB_COMMIT = 1'b1
    } iob_reg_arb_state_t;

endpackage

// File: rtl/iob_reg_ca.sv
// Clock-enabled register with asynchronous active-high reset.
// Latency: 1 cycle from data_i to data_o when cke_i is high.
// Backpressure: none; holds its value while cke_i is low.
// Ports: clk_i, arst_i, cke_i, data_i[DATA_W], data_o[DATA_W].
module iob_reg_ca #(
    parameter int               DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/iob_reg_arb.sv
// Round-robin arbiter that lets N_REQ requesters take turns writing one shared config register.
// Latency: grant on the cycle after valid is seen in IDLE, ready that cycle, data_o/upd_o one cycle later.
// Backpressure: requesters hold valid/data until their one-cycle req_ready_o; cke_i low freezes everything.
// Ports: clk_i, arst_i, cke_i, req_valid_i[N_REQ], req_data_i[N_REQ*DATA_W], req_ready_o[N_REQ],
//        data_o[DATA_W], upd_o, grant_id_o[ID_W], busy_o; lock_i[N_REQ] when IOB_REG_ARB_LOCK_EN is defined.
// Optional macro IOB_REG_ARB_LOCK_EN: a granted requester can hold lock_i to keep the register to itself.
module iob_reg_arb #(
    parameter int                N_REQ   = iob_reg_arb_pkg::IOB_REG_ARB_N_REQ,
    parameter int                DATA_W  = iob_reg_arb_pkg::IOB_REG_ARB_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(iob_reg_arb_pkg::IOB_REG_ARB_RST_VAL),
    localparam int               ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
`ifdef IOB_REG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        lock_i,
`endif
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    upd_o,
    output logic [ID_W-1:0]         grant_id_o,
    output logic                    busy_o
);

    import iob_reg_arb_pkg::*;

    iob_reg_arb_state_t state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               upd_q, upd_d;
    logic               commit;
    logic               locked;
`ifdef IOB_REG_ARB_LOCK_EN
    logic               lock_q, lock_d;
`endif

    // First valid index at or above start, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                                input logic [ID_W-1:0]  start);
        logic [ID_W-1:0] res;
        logic [ID_W-1:0] idx;
        logic            found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(start) + i) % N_REQ);
            if (!found && vld[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        upd_d       = 1'b0;
        commit      = 1'b0;
        req_ready_o = '0;
        locked      = 1'b0;
`ifdef IOB_REG_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IOB_REG_ARB_IDLE: begin
`ifdef IOB_REG_ARB_LOCK_EN
                // A locked owner that has let go of both valid and lock releases the
                // register in this same cycle, so the others can be searched right away.
                if (lock_q && !req_valid_i[grant_q] && !lock_i[grant_q]) begin
                    lock_d = 1'b0;
                end
                locked = lock_d;
`endif
                if (locked) begin
                    if (req_valid_i[grant_q]) begin
                        state_d = IOB_REG_ARB_COMMIT;
                    end
                end else if (|req_valid_i) begin
                    grant_d = rr_pick(req_valid_i, ptr_q);
                    state_d = IOB_REG_ARB_COMMIT;
                end
            end
            IOB_REG_ARB_COMMIT: begin
                state_d = IOB_REG_ARB_IDLE;
                // A requester that dropped valid since the grant gets nothing and
                // keeps its place at the head of the next search.
                if (req_valid_i[grant_q]) begin
                    commit               = cke_i;
                    req_ready_o[grant_q] = cke_i;
                    upd_d                = 1'b1;
                    ptr_d                = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`ifdef IOB_REG_ARB_LOCK_EN
                    if (lock_q) begin
                        ptr_d = ptr_q;
                    end
                    lock_d = lock_i[grant_q];
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IOB_REG_ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            upd_q   <= 1'b0;
`ifdef IOB_REG_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else if (cke_i) begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            upd_q   <= upd_d;
`ifdef IOB_REG_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    iob_reg_ca #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_shared_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (commit),
        .data_i (req_data_i[grant_q*DATA_W +: DATA_W]),
        .data_o (data_o)
    );

    assign upd_o      = upd_q;
    assign grant_id_o = grant_q;
    assign busy_o     = (state_q != IOB_REG_ARB_IDLE);

endmodule
